// File: rtl/fault_frame_tx.sv
// fault_frame_tx: serial fault-status transmitter from the inverter CPLD to the DSP.
// Latches six protection flags into sticky bits. Sends them as a UART-style frame
// (start, D0..D7 LSB first, [even parity], stop) on CPLD_Data, with CPLD2 as the
// frame strobe. A frame goes out periodically, and immediately on any new fault.
// Optional feature macro: FRAME_PARITY_EN adds an even parity bit (11-bit frames).
module fault_frame_tx #(
  parameter int BIT_DIV  = 50,
  parameter int GAP_BITS = 16
) (
  input  logic       CLK_50M,
  input  logic       Rst,
  input  logic [5:0] Fault_In,
  input  logic       Reset_D,
  output logic       CPLD_Data,
  output logic       CPLD2,
  output logic       Tx_Done
);

  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);

`ifdef FRAME_PARITY_EN
  typedef enum logic [2:0] {ST_GAP, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [2:0] {ST_GAP, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [5:0]       fault_p1;
  logic             reset_d_p1;
  logic             reset_d_p2;
  logic [5:0]       sticky;
  logic [5:0]       sticky_nxt;
  logic             clr_edge;
  logic             pending;
  logic             seq;
  logic             seq_nxt;
  logic [7:0]       frame_d;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [2:0]       bit_idx;
  logic             bit_end;
  logic             stop_end;
  logic             enter_start;

`ifdef FRAME_PARITY_EN
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  // Input stage: register the asynchronous DSP/protection inputs once
  always_ff @(posedge CLK_50M) begin
    if (Rst) begin
      fault_p1   <= '0;
      reset_d_p1 <= 1'b0;
      reset_d_p2 <= 1'b0;
    end else begin
      fault_p1   <= Fault_In;
      reset_d_p1 <= Reset_D;
      reset_d_p2 <= reset_d_p1;
    end
  end

  // Derived strobes; a fault present during a clear keeps its sticky bit set
  always_comb begin
    clr_edge    = reset_d_p1 & ~reset_d_p2;
    sticky_nxt  = (clr_edge ? 6'b0 : sticky) | fault_p1;
    bit_end     = (div_cnt == DIV_LAST);
    stop_end    = (state == ST_STOP) && bit_end;
    seq_nxt     = seq ^ stop_end;
    enter_start = (state_nxt == ST_START) && (state != ST_START);
  end

  // Sticky flags, pending request and frame sequence toggle
  always_ff @(posedge CLK_50M) begin
    if (Rst) begin
      sticky  <= '0;
      pending <= 1'b0;
      seq     <= 1'b0;
    end else begin
      sticky  <= sticky_nxt;
      // a new sticky bit in the same cycle as a START must still request a frame
      pending <= (|(sticky_nxt & ~sticky)) | (pending & ~enter_start);
      seq     <= seq_nxt;
    end
  end

  // Frame snapshot, frozen for the whole frame; seq_nxt so back-to-back frames see the toggle
  always_ff @(posedge CLK_50M) begin
    if (enter_start) begin
      frame_d <= {seq_nxt, |fault_p1, sticky};
    end
  end

  // Bit-time divider, gap bit-time counter and data bit index
  always_ff @(posedge CLK_50M) begin
    if (Rst) begin
      div_cnt <= '0;
      gap_cnt <= '0;
      bit_idx <= '0;
    end else begin
      if (enter_start || bit_end) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if ((state != ST_GAP) || (state_nxt != ST_GAP)) begin
        gap_cnt <= '0;
      end else if (bit_end) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
      if (enter_start) begin
        bit_idx <= '0;
      end else if ((state == ST_DATA) && bit_end) begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge CLK_50M) begin
    if (Rst) begin
      state <= ST_GAP;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_GAP: begin
        if (pending || (bit_end && (gap_cnt == GAP_LAST))) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end && (bit_idx == 3'd7)) begin
`ifdef FRAME_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef FRAME_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          state_nxt = pending ? ST_START : ST_GAP;
        end
      end
      default: state_nxt = ST_GAP;
    endcase
  end

  // FSM outputs: line idles high, strobe covers start through stop
  always_comb begin
    CPLD_Data = 1'b1;
    CPLD2     = 1'b0;
    Tx_Done   = 1'b0;
    case (state)
      ST_START: begin
        CPLD_Data = 1'b0;
        CPLD2     = 1'b1;
      end
      ST_DATA: begin
        CPLD_Data = frame_d[bit_idx];
        CPLD2     = 1'b1;
      end
`ifdef FRAME_PARITY_EN
      ST_PARITY: begin
        CPLD_Data = even_parity(frame_d);
        CPLD2     = 1'b1;
      end
`endif
      ST_STOP: begin
        CPLD2   = 1'b1;
        Tx_Done = bit_end;
      end
      default: begin
        CPLD_Data = 1'b1;
        CPLD2     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fault_frame_tx.sv
// Testbench for fault_frame_tx with BIT_DIV=4, GAP_BITS=2.
// Frame-level vector table plus hand-written mid-frame and reset sequences;
// expected data bytes are queued at stimulus time and popped by the receiver task.
module tb_fault_frame_tx;

  localparam int B = 4;
  localparam int G = 2;
`ifdef FRAME_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       CLK_50M = 1'b0;
  logic       Rst     = 1'b1;
  logic       Reset_D = 1'b0;
  logic [5:0] Fault_In = 6'b0;
  logic       CPLD_Data;
  logic       CPLD2;
  logic       Tx_Done;

  int ntests   = 0;
  int nfail    = 0;
  int idle_bad = 0;
  int lat;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [5:0] fault;
    logic       clr;
    int         lat;
    logic [7:0] d;
  } vec_t;
  vec_t vecs[8];

  fault_frame_tx #(.BIT_DIV(B), .GAP_BITS(G)) dut (
    .CLK_50M  (CLK_50M),
    .Rst      (Rst),
    .Fault_In (Fault_In),
    .Reset_D  (Reset_D),
    .CPLD_Data(CPLD_Data),
    .CPLD2    (CPLD2),
    .Tx_Done  (Tx_Done)
  );

  always #10 CLK_50M = ~CLK_50M;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait for CPLD2 to rise; returns the number of posedges waited or -1 on timeout
  task automatic wait_start(input int max, output int n_out);
    n_out = -1;
    for (int n = 1; n <= max; n++) begin
      @(posedge CLK_50M); #1;
      if (CPLD2 === 1'b1) begin
        n_out = n;
        break;
      end
      if ((CPLD_Data !== 1'b1) || (Tx_Done !== 1'b0)) idle_bad++;
    end
  endtask

  // Receive one frame starting on its first START cycle; ends on the last stop cycle
  task automatic rx_check(input string tag);
    logic [FL-1:0] bits;
    logic          held;
    logic [7:0]    d;
    logic [7:0]    e;
    int strobe_bad, done_bad, hold_bad;
    strobe_bad = 0;
    done_bad   = 0;
    hold_bad   = 0;
    held       = 1'b0;
    bits       = '0;
    for (int i = 0; i < FL * B; i++) begin
      if (i > 0) begin
        @(posedge CLK_50M); #1;
      end
      if (CPLD2 !== 1'b1) strobe_bad++;
      if (Tx_Done !== ((i == FL * B - 1) ? 1'b1 : 1'b0)) done_bad++;
      if ((i % B) == 0) held = CPLD_Data;
      else if (CPLD_Data !== held) hold_bad++;
      if ((i % B) == (B / 2)) bits[i / B] = CPLD_Data;
    end
    d = bits[8:1];
    check({tag, "_strobe"}, strobe_bad, 0);
    check({tag, "_txdone"}, done_bad, 0);
    check({tag, "_bithold"}, hold_bad, 0);
    check({tag, "_startbit"}, {31'b0, bits[0]}, 0);
    check({tag, "_stopbit"}, {31'b0, bits[FL-1]}, 1);
    if (exp_q.size() == 0) begin
      ntests++;
      nfail++;
      $display("FAIL %s_data: got 0x%0h, expected no frame", tag, d);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, {24'b0, d}, {24'b0, e});
`ifdef FRAME_PARITY_EN
      check({tag, "_parity"}, {31'b0, bits[9]}, {31'b0, ^e});
`endif
    end
  endtask

  task automatic frame(input string tag, input int lat_exp);
    wait_start(40, lat);
    check({tag, "_lat"}, lat, lat_exp);
    if (lat > 0) rx_check(tag);
    else if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  initial begin
    //            fault      clr   lat  D
    vecs[0] = '{6'b000000, 1'b0, 8, 8'h00}; // idle after reset, seq 0
    vecs[1] = '{6'b000100, 1'b0, 3, 8'hC4}; // new InvOcp1: immediate frame
    vecs[2] = '{6'b000100, 1'b0, 9, 8'h44}; // held, already sticky: periodic
    vecs[3] = '{6'b000000, 1'b0, 9, 8'h84}; // released: sticky remains, live 0
    vecs[4] = '{6'b000000, 1'b1, 9, 8'h00}; // clear with fault released
    vecs[5] = '{6'b000001, 1'b0, 3, 8'hC1}; // new BusOvp
    vecs[6] = '{6'b000001, 1'b1, 9, 8'h41}; // clear while held: set wins
    vecs[7] = '{6'b000000, 1'b1, 9, 8'h80}; // clear after release

    Rst = 1'b1;
    repeat (3) @(posedge CLK_50M);
    #1;
    check("rst_data", {31'b0, CPLD_Data}, 1);
    check("rst_strobe", {31'b0, CPLD2}, 0);
    check("rst_txdone", {31'b0, Tx_Done}, 0);
    Rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      Fault_In = vecs[v].fault;
      exp_q.push_back(vecs[v].d);
      fork
        wait_start(40, lat);
        begin
          if (vecs[v].clr) begin
            Reset_D = 1'b1;
            repeat (2) @(posedge CLK_50M);
            #1;
            Reset_D = 1'b0;
          end
        end
      join
      check($sformatf("vec%0d_lat", v), lat, vecs[v].lat);
      if (lat > 0) rx_check($sformatf("vec%0d", v));
      else if (exp_q.size() > 0) void'(exp_q.pop_front());
    end

    // BusOvp rises during D3; frame in flight unchanged, next frame back-to-back
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hC1);
    wait_start(40, lat);
    check("mid0_lat", lat, 9);
    if (lat > 0) begin
      fork
        rx_check("mid0");
        begin
          repeat (17) @(posedge CLK_50M);
          #1;
          Fault_In = 6'b000001;
        end
      join
    end
    frame("mid1", 1);

    Fault_In = 6'b000000;
    exp_q.push_back(8'h01);
    frame("after_mid", 9);

    // Rst asserted during DATA of the next frame
    wait_start(40, lat);
    check("pre_rst_lat", lat, 9);
    repeat (9) @(posedge CLK_50M);
    #1;
    check("pre_rst_strobe", {31'b0, CPLD2}, 1);
    Rst = 1'b1;
    @(posedge CLK_50M);
    #1;
    check("midrst_data", {31'b0, CPLD_Data}, 1);
    check("midrst_strobe", {31'b0, CPLD2}, 0);
    check("midrst_txdone", {31'b0, Tx_Done}, 0);
    Rst = 1'b0;
    exp_q.push_back(8'h00);
    frame("post_rst", 8);

    check("idle_line", idle_bad, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
